// File: rtl/missile_pkg.sv
// rtl/missile_pkg.sv - shared types and playfield constants for the missile pool
package missile_pkg;

  localparam int COORD_W = 10;

  localparam int PF_X_MIN = 0;
  localparam int PF_X_MAX = 639;
  localparam int PF_Y_MIN = 0;
  localparam int PF_Y_MAX = 479;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // One guard bit above the coordinate width so that underflow wraps above any legal maximum.
  function automatic logic in_bounds(input logic [COORD_W:0] v,
                                     input logic [COORD_W:0] lo,
                                     input logic [COORD_W:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/missile_slot.sv
// rtl/missile_slot.sv - one missile: position, direction, active flag, move and bounds check
module missile_slot
  import missile_pkg::*;
#(
  parameter int STEP  = 4,
  parameter int X_MIN = PF_X_MIN,
  parameter int X_MAX = PF_X_MAX,
  parameter int Y_MIN = PF_Y_MIN,
  parameter int Y_MAX = PF_Y_MAX
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  dir_t               load_dir,
  input  logic               kill,
  output logic               active,
  output logic               active_nxt,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W:0] STEP_W  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] X_MIN_W = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0] X_MAX_W = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] Y_MIN_W = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0] Y_MAX_W = (COORD_W+1)'(Y_MAX);

  logic               active_q, active_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  dir_t               dir_q, dir_d;
  logic [COORD_W:0]   nx, ny;
  logic               in_field;

  always_comb begin
    nx = {1'b0, x_q};
    ny = {1'b0, y_q};
    unique case (dir_q)
      DIR_UP:    ny = {1'b0, y_q} - STEP_W;
      DIR_RIGHT: nx = {1'b0, x_q} + STEP_W;
      DIR_DOWN:  ny = {1'b0, y_q} + STEP_W;
      DIR_LEFT:  nx = {1'b0, x_q} - STEP_W;
    endcase
    in_field = in_bounds(nx, X_MIN_W, X_MAX_W) && in_bounds(ny, Y_MIN_W, Y_MAX_W);
  end

  // A load only ever targets an inactive slot, so it never competes with a move.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    if (load) begin
      active_d = 1'b1;
      x_d      = load_x;
      y_d      = load_y;
      dir_d    = load_dir;
    end else if (active_q) begin
      if (kill || !in_field) begin
        active_d = 1'b0;
      end else begin
        x_d = nx[COORD_W-1:0];
        y_d = ny[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= DIR_UP;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
    end
  end

  assign active     = active_q;
  assign active_nxt = active_d;
  assign x          = x_q;
  assign y          = y_q;

endmodule

// File: rtl/missile_pool.sv
// rtl/missile_pool.sv - pool of missile slots with launch arbitration and fire cooldown
module missile_pool
  import missile_pkg::*;
#(
  parameter int NUM_MISSILES = 4,
  parameter int STEP         = 4,
  parameter int COOLDOWN     = 8,
  parameter int X_MIN        = PF_X_MIN,
  parameter int X_MAX        = PF_X_MAX,
  parameter int Y_MIN        = PF_Y_MIN,
  parameter int Y_MAX        = PF_Y_MAX,
  parameter int SIZE         = 2
) (
  input  logic                              frame_clk,
  input  logic                              Reset,
  input  logic                              fire,
  input  logic [COORD_W-1:0]                fire_x,
  input  logic [COORD_W-1:0]                fire_y,
  input  logic [1:0]                        fire_dir,
  input  logic [NUM_MISSILES-1:0]           hit_mask,
  output logic [NUM_MISSILES-1:0]           active,
  output logic [COORD_W*NUM_MISSILES-1:0]   missile_x,
  output logic [COORD_W*NUM_MISSILES-1:0]   missile_y,
  output logic [COORD_W-1:0]                missile_s,
  output logic                              fire_ack,
  output logic                              pool_full
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [CD_W-1:0]         cd_q, cd_d;
  logic                    fire_ack_q, fire_ack_d;
  logic                    pool_full_q, pool_full_d;
  logic [NUM_MISSILES-1:0] free_oh, load_vec, active_nxt;
  logic                    any_free, origin_ok, launch;

  // Lowest-index free slot, judged on the pre-edge active vector so a slot freed this edge waits one frame.
  always_comb begin
    free_oh  = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_MISSILES; i++) begin
      if (!active[i] && !any_free) begin
        free_oh[i] = 1'b1;
        any_free   = 1'b1;
      end
    end
  end

  always_comb begin
    origin_ok = in_bounds({1'b0, fire_x}, (COORD_W+1)'(X_MIN), (COORD_W+1)'(X_MAX)) &&
                in_bounds({1'b0, fire_y}, (COORD_W+1)'(Y_MIN), (COORD_W+1)'(Y_MAX));
    launch    = fire && (cd_q == '0) && any_free && origin_ok;
    load_vec  = launch ? free_oh : '0;

    cd_d = cd_q;
    if (launch) begin
      cd_d = CD_W'(COOLDOWN);
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end
    fire_ack_d  = launch;
    pool_full_d = &active_nxt;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cd_q        <= '0;
      fire_ack_q  <= 1'b0;
      pool_full_q <= 1'b0;
    end else begin
      cd_q        <= cd_d;
      fire_ack_q  <= fire_ack_d;
      pool_full_q <= pool_full_d;
    end
  end

  for (genvar gi = 0; gi < NUM_MISSILES; gi++) begin : g_slot
    missile_slot #(
      .STEP  (STEP),
      .X_MIN (X_MIN),
      .X_MAX (X_MAX),
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
    ) u_slot (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .load       (load_vec[gi]),
      .load_x     (fire_x),
      .load_y     (fire_y),
      .load_dir   (dir_t'(fire_dir)),
      .kill       (hit_mask[gi]),
      .active     (active[gi]),
      .active_nxt (active_nxt[gi]),
      .x          (missile_x[COORD_W*gi +: COORD_W]),
      .y          (missile_y[COORD_W*gi +: COORD_W])
    );
  end

  assign missile_s = COORD_W'(SIZE);
  assign fire_ack  = fire_ack_q;
  assign pool_full = pool_full_q;

endmodule

// File: tb/tb_missile_pool.sv
// tb/tb_missile_pool.sv - directed and randomized checks of missile_pool against a behavioural model
module tb_missile_pool;

  localparam int N   = 4;
  localparam int STP = 4;
  localparam int CDN = 8;

  logic          frame_clk = 1'b0;
  logic          Reset     = 1'b1;
  logic          fire      = 1'b0;
  logic [9:0]    fire_x    = '0;
  logic [9:0]    fire_y    = '0;
  logic [1:0]    fire_dir  = '0;
  logic [N-1:0]  hit_mask  = '0;
  logic [N-1:0]  active;
  logic [10*N-1:0] missile_x, missile_y;
  logic [9:0]    missile_s;
  logic          fire_ack, pool_full;

  int checks = 0;
  int errors = 0;

  int mx[N], my[N], md[N];
  bit ma[N];
  int mcd;
  bit mack, mfull;

  missile_pool #(
    .NUM_MISSILES(N), .STEP(STP), .COOLDOWN(CDN),
    .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479), .SIZE(2)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .fire      (fire),
    .fire_x    (fire_x),
    .fire_y    (fire_y),
    .fire_dir  (fire_dir),
    .hit_mask  (hit_mask),
    .active    (active),
    .missile_x (missile_x),
    .missile_y (missile_y),
    .missile_s (missile_s),
    .fire_ack  (fire_ack),
    .pool_full (pool_full)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; md[i] = 0; ma[i] = 0;
    end
    mcd = 0; mack = 0; mfull = 0;
  endtask

  task automatic model_edge(input bit f, input int fx, input int fy, input int fd, input logic [N-1:0] hit);
    int  nx, ny, free;
    bit  launch, all;
    free = -1;
    for (int i = 0; i < N; i++) if (!ma[i] && free < 0) free = i;
    launch = f && (mcd == 0) && (free >= 0) && (fx <= 639) && (fy <= 479);
    for (int i = 0; i < N; i++) begin
      if (ma[i]) begin
        nx = mx[i]; ny = my[i];
        case (md[i])
          0: ny = ny - STP;
          1: nx = nx + STP;
          2: ny = ny + STP;
          default: nx = nx - STP;
        endcase
        if (hit[i] || nx < 0 || nx > 639 || ny < 0 || ny > 479) ma[i] = 0;
        else begin mx[i] = nx; my[i] = ny; end
      end
    end
    if (launch) begin
      mx[free] = fx; my[free] = fy; md[free] = fd; ma[free] = 1;
      mcd = CDN;
    end else if (mcd > 0) begin
      mcd = mcd - 1;
    end
    mack = launch;
    all = 1;
    for (int i = 0; i < N; i++) if (!ma[i]) all = 0;
    mfull = all;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ea;
    for (int i = 0; i < N; i++) ea[i] = ma[i];
    chk({tag, "_active"}, active, ea);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), missile_x[10*i +: 10], mx[i]);
      chk($sformatf("%s_y%0d", tag, i), missile_y[10*i +: 10], my[i]);
    end
    chk({tag, "_ack"}, fire_ack, mack);
    chk({tag, "_full"}, pool_full, mfull);
  endtask

  task automatic step(input string tag, input bit f, input int fx, input int fy, input int fd, input logic [N-1:0] hit);
    fire = f; fire_x = 10'(fx); fire_y = 10'(fy); fire_dir = 2'(fd); hit_mask = hit;
    @(posedge frame_clk);
    model_edge(f, fx, fy, fd, hit);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    Reset = 1'b0;
  endtask

  initial begin
    int fx, fy;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    check_all("reset");
    chk("size", missile_s, 10'd2);
    Reset = 1'b0;

    // single launch upward, then two moves
    step("launch_up", 1, 320, 240, 0, '0);
    chk("launch_up_y0", missile_y[9:0], 10'd240);
    chk("launch_up_ack", fire_ack, 1'b1);
    step("move1", 0, 0, 0, 0, '0);
    chk("move1_y0", missile_y[9:0], 10'd236);
    step("move2", 0, 0, 0, 0, '0);
    chk("move2_y0", missile_y[9:0], 10'd232);
    chk("move2_others", active, 4'b0001);

    // held fire fills the pool at the cooldown rate
    do_reset("rst_hold");
    for (int e = 0; e <= 36; e++) begin
      step("hold", 1, 320, 240, 0, '0);
      chk($sformatf("hold_ack_e%0d", e), fire_ack, (e % 9 == 0) && (e < 36));
      chk($sformatf("hold_full_e%0d", e), pool_full, e >= 27);
    end
    // hit frees slot0 but it is not launchable until the next edge
    step("hit_fire", 1, 100, 200, 1, 4'b0001);
    chk("hit_fire_ack", fire_ack, 1'b0);
    chk("hit_fire_active", active, 4'b1110);
    step("refill", 1, 100, 200, 1, '0);
    chk("refill_ack", fire_ack, 1'b1);
    chk("refill_x0", missile_x[9:0], 10'd100);

    // left exit with underflow
    do_reset("rst_left");
    step("left_l", 1, 5, 100, 3, '0);
    step("left_m1", 0, 0, 0, 0, '0);
    chk("left_x1", missile_x[9:0], 10'd1);
    step("left_m2", 0, 0, 0, 0, '0);
    chk("left_gone", active[0], 1'b0);
    chk("left_hold", missile_x[9:0], 10'd1);

    // right exit
    do_reset("rst_right");
    step("right_l", 1, 637, 100, 1, '0);
    step("right_m1", 0, 0, 0, 0, '0);
    chk("right_gone", active[0], 1'b0);
    chk("right_hold", missile_x[9:0], 10'd637);

    // out-of-range origin leaves cooldown at zero
    do_reset("rst_oor");
    step("oor", 1, 700, 100, 0, '0);
    chk("oor_ack", fire_ack, 1'b0);
    step("oor_next", 1, 300, 100, 0, '0);
    chk("oor_next_ack", fire_ack, 1'b1);

    // asynchronous reset with three missiles in flight
    do_reset("rst_async_pre");
    for (int e = 0; e < 19; e++) step("fly3", 1, 320, 400, 0, '0);
    chk("fly3_active", active, 4'b0111);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async");
    #1;
    Reset = 1'b0;
    step("after_async", 1, 50, 60, 2, '0);
    chk("after_async_ack", fire_ack, 1'b1);

    // randomized traffic against the model
    do_reset("rst_rand");
    for (int e = 0; e < 400; e++) begin
      fx = ($urandom_range(0, 7) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
      fy = ($urandom_range(0, 7) == 0) ? $urandom_range(480, 1023) : $urandom_range(0, 479);
      step("rand", $urandom_range(0, 2) != 0, fx, fy, $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
